mc_control: RTL and testbench
=============================

# mc_control

Multicycle main controller for the MIPS-subset datapath. Sequences each instruction through fetch, decode, execute, memory and writeback cycles. Drives the 3-bit ALU control line consumed by the ALU and reads back its `zout`/`nout` status flags to resolve conditional branches. Sits between the instruction register fields and every datapath mux and write-enable.

## Interface
Parameters:
- none; state width is fixed at 4 bits.

Ports:
- `clk` in 1: single clock; all state updates on its rising edge.
- `reset_n` in 1: asynchronous, active-low reset.
- `opcode` in 6: IR[31:26].
- `funct` in 6: IR[5:0].
- `rt` in 5: IR[20:16]; used only by the `REGIMM` branch.
- `zout` in 1: ALU zero flag.
- `nout` in 1: ALU negative flag (result bit 31).
- `gin` out 3: ALU control line. 010 add, 110 sub, 111 slt, 000 and, 001 or.
- `alu_srca` out 1: 0 selects PC, 1 selects register A.
- `alu_srcb` out 2: 00 register B, 01 constant 4, 10 sign-extended imm, 11 sign-extended imm shifted left by 2.
- `iord` out 1: memory address source. 0 selects PC, 1 selects ALUOut.
- `mem_rd` out 1: memory read strobe.
- `mem_wr` out 1: memory write strobe.
- `ir_we` out 1: instruction register load.
- `reg_we` out 1: register file write.
- `reg_dst` out 1: 1 selects rd, 0 selects rt.
- `mem_to_reg` out 1: 1 selects MDR, 0 selects ALUOut.
- `pc_we` out 1: PC load.
- `pc_src` out 2: 00 ALU result, 01 ALUOut, 10 jump target.
- `state` out 4: current state, exported for debug.
- `illegal` out 1: unsupported instruction detected.

## Operation
States and encodings:
- `RST`=0: all outputs 0. Next state is `FETCH`.
- `FETCH`=1:
  - `mem_rd`=1, `ir_we`=1, `iord`=0.
  - `alu_srca`=0, `alu_srcb`=01, `gin`=010.
  - `pc_src`=00, `pc_we`=1.
  - Next state is `DECODE`.
- `DECODE`=2: `alu_srca`=0, `alu_srcb`=11, `gin`=010, which computes the branch target into ALUOut. Dispatch by opcode:
  - 0x00 goes to `REXEC`, only if `funct` is one of 0x20/0x22/0x24/0x25/0x2A.
  - 0x23 and 0x2B go to `MEMADR`.
  - 0x08 goes to `IEXEC`.
  - 0x04 and 0x05 go to `BRANCH`.
  - 0x02 goes to `JUMP`.
  - Anything else asserts `illegal`=1 for this cycle and returns to `FETCH`. No datapath write occurs.
- `MEMADR`=3: `alu_srca`=1, `alu_srcb`=10, `gin`=010. Goes to `MEMRD` for lw, `MEMWR` for sw.
- `MEMRD`=4: `mem_rd`=1, `iord`=1. Next state is `MEMWB`.
- `MEMWB`=5: `reg_we`=1, `reg_dst`=0, `mem_to_reg`=1. Next state is `FETCH`.
- `MEMWR`=6: `mem_wr`=1, `iord`=1. Next state is `FETCH`.
- `REXEC`=7: `alu_srca`=1, `alu_srcb`=00. `gin` from funct: 0x20 maps to 010, 0x22 to 110, 0x24 to 000, 0x25 to 001, 0x2A to 111. Next state is `RWB`.
- `RWB`=8: `reg_we`=1, `reg_dst`=1, `mem_to_reg`=0. Next state is `FETCH`.
- `IEXEC`=9: `alu_srca`=1, `alu_srcb`=10, `gin`=010. Next state is `IWB`.
- `IWB`=10: `reg_we`=1, `reg_dst`=0, `mem_to_reg`=0. Next state is `FETCH`.
- `BRANCH`=11: `alu_srca`=1, `alu_srcb`=00, `gin`=110, `pc_src`=01. `pc_we` is set as follows:
  - beq: `zout`.
  - bne: `~zout`.
  - bltz (macro only): `nout`.
  - Next state is `FETCH`.
- `JUMP`=12: `pc_src`=10, `pc_we`=1. Next state is `FETCH`.
- Encodings 13–15 output all 0 and go to `FETCH` next cycle.

Output rules:
- Any output not listed for a state is 0.
- `gin` is 010 in every state that does not specify it.
- `opcode`/`funct`/`rt` are sampled from the IR, which is stable from `DECODE` through the end of the instruction. The controller does not register them.

## Timing
- Outputs are Moore, decoded from the state register.
- The only exception is `pc_we` in `BRANCH`, which is a combinational function of `zout`/`nout` within the same cycle.
- Cycles from `FETCH` to the next `FETCH`:
  - lw 5
  - sw 4
  - R-type 4
  - addi 4
  - branch 3
  - j 3
  - illegal 2
- When `reset_n` falls, at any point including mid-instruction, `state` becomes `RST` immediately and all outputs go to 0 asynchronously. No partial write may be issued after the reset edge.
- The first `FETCH` occurs on the second rising edge after `reset_n` is deasserted.

## Configuration
- `MC_CONTROL_BLTZ_EN` defined:
  - opcode 0x01 with `rt`=0 dispatches to `BRANCH` and is taken when `nout`=1.
  - opcode 0x01 with `rt`≠0 is illegal.
- Not defined: opcode 0x01 is illegal and `nout` is unused.

## Test plan
- Reset: hold `reset_n`=0 for 3 cycles, then release. Required: `state`=0 with all outputs 0 during reset; `state`=1 with `pc_we`=1, `mem_rd`=1, `gin`=010 on the 2nd edge after release.
- lw (opcode 0x23): state sequence 1,2,3,4,5,1. Required: `gin`=010 in `MEMADR`; `iord`=1 in `MEMRD`; `reg_we`=1, `mem_to_reg`=1 in `MEMWB`.
- R-type: funct 0x22 gives `gin`=110 in `REXEC`; funct 0x2A gives `gin`=111; funct 0x25 gives `gin`=001. `reg_dst`=1 in `RWB`.
- beq: `zout`=1 gives `pc_we`=1, `pc_src`=01 in `BRANCH`; `zout`=0 gives `pc_we`=0. bne gives the opposite result for each case.
- Illegal opcode 0x3F: `illegal`=1 for exactly one cycle in `DECODE`, no `reg_we`/`mem_wr`, then `FETCH`. With `MC_CONTROL_BLTZ_EN`, opcode 0x01 with `rt`=0 and `nout`=1 gives `pc_we`=1.
- Reset mid-instruction: assert `reset_n`=0 during `MEMWR`. Required: `mem_wr` drops to 0 without waiting for a clock edge, and `state`=0.

Source files
------------

// File: rtl/mc_control.sv
// Multicycle MIPS-subset main controller: Moore FSM driving datapath muxes, strobes and ALU control.
// Optional MC_CONTROL_BLTZ_EN adds bltz (opcode 0x01, rt=0) as a branch taken on the ALU negative flag.
module mc_control (
  input  logic       clk,
  input  logic       reset_n,
  input  logic [5:0] opcode,
  input  logic [5:0] funct,
  input  logic [4:0] rt,
  input  logic       zout,
  input  logic       nout,
  output logic [2:0] gin,
  output logic       alu_srca,
  output logic [1:0] alu_srcb,
  output logic       iord,
  output logic       mem_rd,
  output logic       mem_wr,
  output logic       ir_we,
  output logic       reg_we,
  output logic       reg_dst,
  output logic       mem_to_reg,
  output logic       pc_we,
  output logic [1:0] pc_src,
  output logic [3:0] state,
  output logic       illegal
);

  typedef enum logic [3:0] {
    RST    = 4'd0,
    FETCH  = 4'd1,
    DECODE = 4'd2,
    MEMADR = 4'd3,
    MEMRD  = 4'd4,
    MEMWB  = 4'd5,
    MEMWR  = 4'd6,
    REXEC  = 4'd7,
    RWB    = 4'd8,
    IEXEC  = 4'd9,
    IWB    = 4'd10,
    BRANCH = 4'd11,
    JUMP   = 4'd12
  } state_t;

  localparam logic [2:0] GIN_ADD = 3'b010;
  localparam logic [2:0] GIN_SUB = 3'b110;
  localparam logic [2:0] GIN_SLT = 3'b111;
  localparam logic [2:0] GIN_AND = 3'b000;
  localparam logic [2:0] GIN_OR  = 3'b001;

  state_t cur, nxt;
  logic   run;
  logic   taken;

  function automatic logic funct_ok(input logic [5:0] f);
    return (f == 6'h20) || (f == 6'h22) || (f == 6'h24) || (f == 6'h25) || (f == 6'h2A);
  endfunction

  function automatic logic [2:0] funct_gin(input logic [5:0] f);
    case (f)
      6'h22:   return GIN_SUB;
      6'h24:   return GIN_AND;
      6'h25:   return GIN_OR;
      6'h2A:   return GIN_SLT;
      default: return GIN_ADD;
    endcase
  endfunction

  // run holds the FSM in RST for one extra edge so the first FETCH lands on the second edge after release
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cur <= RST;
      run <= 1'b0;
    end else begin
      cur <= nxt;
      run <= 1'b1;
    end
  end

  assign state = cur;

  always_comb begin
    nxt = FETCH;
    case (cur)
      RST:    nxt = run ? FETCH : RST;
      FETCH:  nxt = DECODE;
      DECODE: begin
        case (opcode)
          6'h00:        nxt = funct_ok(funct) ? REXEC : FETCH;
          6'h23, 6'h2B: nxt = MEMADR;
          6'h08:        nxt = IEXEC;
          6'h04, 6'h05: nxt = BRANCH;
          6'h02:        nxt = JUMP;
`ifdef MC_CONTROL_BLTZ_EN
          6'h01:        nxt = (rt == 5'd0) ? BRANCH : FETCH;
`endif
          default:      nxt = FETCH;
        endcase
      end
      MEMADR: nxt = (opcode == 6'h2B) ? MEMWR : MEMRD;
      MEMRD:  nxt = MEMWB;
      REXEC:  nxt = RWB;
      IEXEC:  nxt = IWB;
      default: nxt = FETCH;
    endcase
  end

  // Branch resolution is the one combinational path from the ALU flags into an output
  always_comb begin
    taken = 1'b0;
    case (opcode)
      6'h04:   taken = zout;
      6'h05:   taken = ~zout;
`ifdef MC_CONTROL_BLTZ_EN
      6'h01:   taken = nout;
`endif
      default: taken = 1'b0;
    endcase
  end

`ifndef MC_CONTROL_BLTZ_EN
  logic unused_bltz;
  assign unused_bltz = nout ^ (^rt);
`endif

  always_comb begin
    gin        = GIN_ADD;
    alu_srca   = 1'b0;
    alu_srcb   = 2'b00;
    iord       = 1'b0;
    mem_rd     = 1'b0;
    mem_wr     = 1'b0;
    ir_we      = 1'b0;
    reg_we     = 1'b0;
    reg_dst    = 1'b0;
    mem_to_reg = 1'b0;
    pc_we      = 1'b0;
    pc_src     = 2'b00;
    illegal    = 1'b0;
    case (cur)
      RST:    gin = 3'b000;
      FETCH: begin
        mem_rd   = 1'b1;
        ir_we    = 1'b1;
        alu_srcb = 2'b01;
        pc_we    = 1'b1;
      end
      DECODE: begin
        alu_srcb = 2'b11;
        illegal  = (nxt == FETCH);
      end
      MEMADR: begin
        alu_srca = 1'b1;
        alu_srcb = 2'b10;
      end
      MEMRD: begin
        mem_rd = 1'b1;
        iord   = 1'b1;
      end
      MEMWB: begin
        reg_we     = 1'b1;
        mem_to_reg = 1'b1;
      end
      MEMWR: begin
        mem_wr = 1'b1;
        iord   = 1'b1;
      end
      REXEC: begin
        alu_srca = 1'b1;
        gin      = funct_gin(funct);
      end
      RWB: begin
        reg_we  = 1'b1;
        reg_dst = 1'b1;
      end
      IEXEC: begin
        alu_srca = 1'b1;
        alu_srcb = 2'b10;
      end
      IWB:    reg_we = 1'b1;
      BRANCH: begin
        alu_srca = 1'b1;
        gin      = GIN_SUB;
        pc_src   = 2'b01;
        pc_we    = taken;
      end
      JUMP: begin
        pc_src = 2'b10;
        pc_we  = 1'b1;
      end
      default: gin = 3'b000;
    endcase
  end

endmodule

// File: tb/tb_mc_control.sv
// Directed bench for mc_control: expected output snapshots are queued per step and popped at each sample point.
module tb_mc_control;

  logic       clk = 1'b0;
  logic       reset_n;
  logic [5:0] opcode;
  logic [5:0] funct;
  logic [4:0] rt;
  logic       zout;
  logic       nout;
  logic [2:0] gin;
  logic       alu_srca;
  logic [1:0] alu_srcb;
  logic       iord, mem_rd, mem_wr, ir_we, reg_we, reg_dst, mem_to_reg, pc_we, illegal;
  logic [1:0] pc_src;
  logic [3:0] state;

  int ncomp = 0;
  int nfail = 0;
  logic [20:0] exp_q[$];
  string       tag_q[$];

  mc_control dut (
    .clk(clk), .reset_n(reset_n), .opcode(opcode), .funct(funct), .rt(rt),
    .zout(zout), .nout(nout), .gin(gin), .alu_srca(alu_srca), .alu_srcb(alu_srcb),
    .iord(iord), .mem_rd(mem_rd), .mem_wr(mem_wr), .ir_we(ir_we), .reg_we(reg_we),
    .reg_dst(reg_dst), .mem_to_reg(mem_to_reg), .pc_we(pc_we), .pc_src(pc_src),
    .state(state), .illegal(illegal)
  );

  always #5 clk = ~clk;

  // {state, gin, srca, srcb, iord, mem_rd, mem_wr, ir_we, reg_we, reg_dst, mem_to_reg, pc_we, pc_src, illegal}
  function automatic logic [20:0] ov(input logic [3:0] st, input logic [2:0] g, input logic sa,
                                     input logic [1:0] sb, input logic io, input logic rd,
                                     input logic wr, input logic irw, input logic rw,
                                     input logic rdst, input logic m2r, input logic pw,
                                     input logic [1:0] ps, input logic il);
    return {st, g, sa, sb, io, rd, wr, irw, rw, rdst, m2r, pw, ps, il};
  endfunction

  function automatic logic [20:0] e_rst();    return ov(0, 3'b000, 0, 2'b00, 0, 0, 0, 0, 0, 0, 0, 0, 2'b00, 0); endfunction
  function automatic logic [20:0] e_fetch();  return ov(1, 3'b010, 0, 2'b01, 0, 1, 0, 1, 0, 0, 0, 1, 2'b00, 0); endfunction
  function automatic logic [20:0] e_decode(input logic il);
    return ov(2, 3'b010, 0, 2'b11, 0, 0, 0, 0, 0, 0, 0, 0, 2'b00, il);
  endfunction
  function automatic logic [20:0] e_memadr(); return ov(3, 3'b010, 1, 2'b10, 0, 0, 0, 0, 0, 0, 0, 0, 2'b00, 0); endfunction
  function automatic logic [20:0] e_memrd();  return ov(4, 3'b010, 0, 2'b00, 1, 1, 0, 0, 0, 0, 0, 0, 2'b00, 0); endfunction
  function automatic logic [20:0] e_memwb();  return ov(5, 3'b010, 0, 2'b00, 0, 0, 0, 0, 1, 0, 1, 0, 2'b00, 0); endfunction
  function automatic logic [20:0] e_memwr();  return ov(6, 3'b010, 0, 2'b00, 1, 0, 1, 0, 0, 0, 0, 0, 2'b00, 0); endfunction
  function automatic logic [20:0] e_rexec(input logic [2:0] g);
    return ov(7, g, 1, 2'b00, 0, 0, 0, 0, 0, 0, 0, 0, 2'b00, 0);
  endfunction
  function automatic logic [20:0] e_rwb();    return ov(8, 3'b010, 0, 2'b00, 0, 0, 0, 0, 1, 1, 0, 0, 2'b00, 0); endfunction
  function automatic logic [20:0] e_iexec();  return ov(9, 3'b010, 1, 2'b10, 0, 0, 0, 0, 0, 0, 0, 0, 2'b00, 0); endfunction
  function automatic logic [20:0] e_iwb();    return ov(10, 3'b010, 0, 2'b00, 0, 0, 0, 0, 1, 0, 0, 0, 2'b00, 0); endfunction
  function automatic logic [20:0] e_branch(input logic pw);
    return ov(11, 3'b110, 1, 2'b00, 0, 0, 0, 0, 0, 0, 0, pw, 2'b01, 0);
  endfunction
  function automatic logic [20:0] e_jump();   return ov(12, 3'b010, 0, 2'b00, 0, 0, 0, 0, 0, 0, 0, 1, 2'b10, 0); endfunction

  task automatic check();
    logic [20:0] got, e;
    string t;
    got = {state, gin, alu_srca, alu_srcb, iord, mem_rd, mem_wr, ir_we, reg_we, reg_dst,
           mem_to_reg, pc_we, pc_src, illegal};
    e = exp_q.pop_front();
    t = tag_q.pop_front();
    ncomp++;
    assert (got === e) else begin
      nfail++;
      $error("FAIL %s: observed=%h expected=%h", t, got, e);
    end
  endtask

  // Expectation for the state reached after the next rising edge
  task automatic cyc(input string t, input logic [20:0] e);
    exp_q.push_back(e);
    tag_q.push_back(t);
    @(posedge clk);
    #1;
    check();
  endtask

  // Expectation for the current cycle, no edge
  task automatic now(input string t, input logic [20:0] e);
    exp_q.push_back(e);
    tag_q.push_back(t);
    check();
  endtask

  logic [5:0] rfn[5];
  logic [2:0] rgv[5];
  logic [5:0] bop[4];
  logic       bz[4];
  logic       bpw[4];

  initial begin
    rfn = '{6'h22, 6'h2A, 6'h25, 6'h20, 6'h24};
    rgv = '{3'b110, 3'b111, 3'b001, 3'b010, 3'b000};
    bop = '{6'h04, 6'h04, 6'h05, 6'h05};
    bz  = '{1'b1, 1'b0, 1'b1, 1'b0};
    bpw = '{1'b1, 1'b0, 1'b0, 1'b1};

    reset_n = 1'b0;
    opcode = 6'h00; funct = 6'h00; rt = 5'd0; zout = 1'b0; nout = 1'b0;
    #1;
    now("rst_init", e_rst());
    for (int i = 0; i < 3; i++) cyc($sformatf("rst_hold%0d", i), e_rst());

    @(negedge clk);
    reset_n = 1'b1;
    cyc("rel_edge1", e_rst());
    cyc("rel_edge2_fetch", e_fetch());

    // lw
    opcode = 6'h23;
    cyc("lw_decode", e_decode(1'b0));
    cyc("lw_memadr", e_memadr());
    cyc("lw_memrd", e_memrd());
    cyc("lw_memwb", e_memwb());
    cyc("lw_fetch", e_fetch());

    // R-type funct table
    for (int i = 0; i < 5; i++) begin
      opcode = 6'h00;
      funct  = rfn[i];
      cyc($sformatf("r%0h_decode", rfn[i]), e_decode(1'b0));
      cyc($sformatf("r%0h_rexec", rfn[i]), e_rexec(rgv[i]));
      cyc($sformatf("r%0h_rwb", rfn[i]), e_rwb());
      cyc($sformatf("r%0h_fetch", rfn[i]), e_fetch());
    end

    // addi
    opcode = 6'h08;
    cyc("addi_decode", e_decode(1'b0));
    cyc("addi_iexec", e_iexec());
    cyc("addi_iwb", e_iwb());
    cyc("addi_fetch", e_fetch());

    // beq/bne, then flip zout inside BRANCH to see pc_we follow without an edge
    for (int i = 0; i < 4; i++) begin
      opcode = bop[i];
      zout   = bz[i];
      cyc($sformatf("br%0h_z%0d_decode", bop[i], bz[i]), e_decode(1'b0));
      cyc($sformatf("br%0h_z%0d_branch", bop[i], bz[i]), e_branch(bpw[i]));
      zout = ~bz[i];
      #1;
      now($sformatf("br%0h_z%0d_flip", bop[i], bz[i]), e_branch(~bpw[i]));
      cyc($sformatf("br%0h_z%0d_fetch", bop[i], bz[i]), e_fetch());
    end
    zout = 1'b0;

    // j
    opcode = 6'h02;
    cyc("j_decode", e_decode(1'b0));
    cyc("j_jump", e_jump());
    cyc("j_fetch", e_fetch());

    // illegal opcode and illegal R-type funct
    opcode = 6'h3F;
    cyc("ill3f_decode", e_decode(1'b1));
    cyc("ill3f_fetch", e_fetch());
    opcode = 6'h00;
    funct  = 6'h21;
    cyc("illfn_decode", e_decode(1'b1));
    cyc("illfn_fetch", e_fetch());

    // opcode 0x01 (bltz when enabled)
    opcode = 6'h01;
    rt     = 5'd0;
    nout   = 1'b1;
`ifdef MC_CONTROL_BLTZ_EN
    cyc("bltz_decode", e_decode(1'b0));
    cyc("bltz_branch", e_branch(1'b1));
    nout = 1'b0;
    #1;
    now("bltz_nout0", e_branch(1'b0));
    cyc("bltz_fetch", e_fetch());
    rt = 5'd1;
    cyc("bltz_rt1_decode", e_decode(1'b1));
    cyc("bltz_rt1_fetch", e_fetch());
`else
    cyc("op01_decode", e_decode(1'b1));
    cyc("op01_fetch", e_fetch());
`endif
    nout = 1'b0;
    rt   = 5'd0;

    // sw, reset asserted mid-MEMWR
    opcode = 6'h2B;
    cyc("sw_decode", e_decode(1'b0));
    cyc("sw_memadr", e_memadr());
    cyc("sw_memwr", e_memwr());
    #2;
    reset_n = 1'b0;
    #1;
    now("async_rst_memwr", e_rst());
    cyc("rst_mid_hold", e_rst());
    @(negedge clk);
    reset_n = 1'b1;
    cyc("rel2_edge1", e_rst());
    cyc("rel2_edge2_fetch", e_fetch());

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncomp, nfail);
    $finish;
  end

endmodule
